adder_seq_ctrl: RTL

ADDER_SEQ_CTRL -- requirements
Module: adder_seq_ctrl

---
 rtl/adder_seq_ctrl_if.sv | 28 ++
 rtl/adder_seq_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/adder_seq_ctrl_if.sv
// Request/result bundle for the nibble-serial adder/subtractor.
// The slave side is the arithmetic block and the master side is whoever issues operations.
interface adder_seq_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             op_sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport slave (
    input  in_valid, op_sub, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );

  modport master (
    output in_valid, op_sub, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/adder_seq_ctrl.sv
// Sequential adder/subtractor that reuses one 4-bit carry-lookahead slice,
// processing one nibble per clock from LSB to MSB.

module cla_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Carries are flattened lookahead terms rather than a ripple chain.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s    = p ^ c[3:0];
  assign cout = c[4];
endmodule

module adder_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  adder_seq_ctrl_if.slave bus
);
  localparam int NIB   = WIDTH / 4;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic signed [WIDTH-1:0] a_r;
  logic signed [WIDTH-1:0] beff_r;
  logic signed [WIDTH-1:0] sum_r;
  logic signed [WIDTH-1:0] sum_d;
  logic                    carry_r;
  logic [CNT_W-1:0]        cnt_r;
  logic [3:0]              nib_a;
  logic [3:0]              nib_b;
  logic [3:0]              nib_s;
  logic                    nib_co;

  function automatic logic [3:0] nibble(input logic [WIDTH-1:0] v,
                                        input logic [CNT_W-1:0] k);
    logic [3:0] r;
    r = 4'h0;
    for (int i = 0; i < NIB; i++) begin
      if (k == CNT_W'(i)) r = v[4*i +: 4];
    end
    return r;
  endfunction

  function automatic logic signed_ovf(input logic signed [WIDTH-1:0] x,
                                      input logic signed [WIDTH-1:0] y,
                                      input logic signed [WIDTH-1:0] s);
    return (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
  endfunction

  assign nib_a = nibble(a_r, cnt_r);
  assign nib_b = nibble(beff_r, cnt_r);

  cla_4 u_cla (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_r),
    .s    (nib_s),
    .cout (nib_co)
  );

  always_comb begin
    sum_d = sum_r;
    for (int i = 0; i < NIB; i++) begin
      if (cnt_r == CNT_W'(i)) sum_d[4*i +: 4] = nib_s;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)      state_d = RUN;
      RUN:     if (cnt_r == LAST)     state_d = DONE;
      DONE:    if (bus.out_ready)     state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_r     <= '0;
      beff_r  <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      cnt_r   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_r     <= bus.a;
            beff_r  <= bus.op_sub ? ~bus.b : bus.b;
            carry_r <= bus.op_sub ? 1'b1 : bus.cin;
            cnt_r   <= '0;
          end
        end
        RUN: begin
          sum_r   <= sum_d;
          carry_r <= nib_co;
          // Counter parks on the last nibble so DONE never sees a wrapped index.
          if (cnt_r != LAST) cnt_r <= cnt_r + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.sum       = sum_r;
  assign bus.cout      = carry_r;
  assign bus.ovf       = signed_ovf(a_r, beff_r, sum_r);
endmodule
